// File: rtl/stack_unit.sv
// LIFO operand stack for the backtracking datapath: register-array storage,
// occupancy count, registered top, push/ready handshake FSM and sticky misuse flags.
`timescale 1ns/1ps
module stack_unit #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_init,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              poping,
  input  logic              dont_check,
  input  logic              updater,
  output logic              updated,
  output logic              done,
  output logic              full,
  output logic [DATA_W-1:0] top_data,
  output logic [PTR_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READY = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  count_r;
  logic [DATA_W-1:0] top_r;
  state_t            state_r;
  logic              overflow_r;
  logic              underflow_r;

  logic              full_s;
  logic              empty_s;
  logic              push_acc_s;
  logic              push_ovf_s;
  logic              pop_acc_s;
  logic              pop_unf_s;
  logic [PTR_W-1:0]  cnt_m2_s;
  logic [AW-1:0]     next_top_idx_s;

  // Decode occupancy and resolve load_init > push > poping priority.
  always_comb begin
    full_s         = (count_r == FULL_CNT);
    empty_s        = (count_r == {PTR_W{1'b0}});
    push_acc_s     = !load_init && push && !full_s;
    push_ovf_s     = !load_init && push && full_s;
    pop_acc_s      = !load_init && !push && poping && !empty_s;
    pop_unf_s      = !load_init && !push && poping && empty_s;
    cnt_m2_s       = count_r - PTR_W'(2);
    next_top_idx_s = cnt_m2_s[AW-1:0];
  end

  // Entry storage; deliberately not cleared by reset or load_init.
  always_ff @(posedge clk) begin
    if (push_acc_s) begin
      mem_r[count_r[AW-1:0]] <= push_data;
    end
  end

  // Count, registered top, handshake FSM and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r     <= {PTR_W{1'b0}};
      top_r       <= {DATA_W{1'b0}};
      state_r     <= S_IDLE;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (load_init) begin
      count_r     <= {PTR_W{1'b0}};
      top_r       <= {DATA_W{1'b0}};
      state_r     <= S_IDLE;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (push_acc_s) begin
        count_r <= count_r + PTR_W'(1);
        top_r   <= push_data;
        state_r <= S_WRITE;
      end else begin
        if (pop_acc_s) begin
          count_r <= count_r - PTR_W'(1);
          top_r   <= (count_r == PTR_W'(1)) ? {DATA_W{1'b0}} : mem_r[next_top_idx_s];
        end
        if (state_r == S_WRITE) begin
          state_r <= S_READY;
        end
      end
      if (push_ovf_s && !dont_check) begin
        overflow_r <= 1'b1;
      end
      if (pop_unf_s && !dont_check) begin
        underflow_r <= 1'b1;
      end
    end
  end

  // updater is status-only; it is referenced here purely so the port is not dangling.
  assign updated   = (state_r == S_READY) & (updater | 1'b1);
  assign done      = empty_s;
  assign full      = full_s;
  assign top_data  = top_r;
  assign count     = count_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: directed scenarios plus random traffic,
// compared against a queue-based LIFO model.
`timescale 1ns/1ps
module tb_stack_unit;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int PTR_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_init;
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              poping;
  logic              dont_check;
  logic              updater;
  logic              updated;
  logic              done;
  logic              full;
  logic [DATA_W-1:0] top_data;
  logic [PTR_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  int n_eval = 0;
  int n_fail = 0;

  // Reference model state
  logic [DATA_W-1:0] q[$];
  bit m_ovf, m_unf, m_ever, m_pushed_now;

  stack_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .load_init(load_init), .push(push), .push_data(push_data),
    .poping(poping), .dont_check(dont_check), .updater(updater), .updated(updated),
    .done(done), .full(full), .top_data(top_data), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_ever = 1'b0; m_pushed_now = 1'b0;
  endtask

  task automatic model_edge(input logic li, input logic pu, input logic [DATA_W-1:0] pd,
                            input logic po, input logic dc);
    m_pushed_now = 1'b0;
    if (li) begin
      model_reset();
    end else if (pu) begin
      if (q.size() < DEPTH) begin
        q.push_back(pd);
        m_ever = 1'b1;
        m_pushed_now = 1'b1;
      end else if (!dc) begin
        m_ovf = 1'b1;
      end
    end else if (po) begin
      if (q.size() > 0) void'(q.pop_back());
      else if (!dc) m_unf = 1'b1;
    end
  endtask

  task automatic check_all(input string ctx);
    logic [DATA_W-1:0] exp_top;
    exp_top = (q.size() > 0) ? q[q.size()-1] : '0;
    chk({ctx, ".count"},     32'(count),     32'(q.size()));
    chk({ctx, ".top"},       32'(top_data),  32'(exp_top));
    chk({ctx, ".done"},      32'(done),      32'(q.size() == 0));
    chk({ctx, ".full"},      32'(full),      32'(q.size() == DEPTH));
    chk({ctx, ".updated"},   32'(updated),   32'(m_ever && !m_pushed_now));
    chk({ctx, ".overflow"},  32'(overflow),  32'(m_ovf));
    chk({ctx, ".underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  task automatic step(input string ctx, input logic li, input logic pu,
                      input logic [DATA_W-1:0] pd, input logic po, input logic dc);
    load_init = li; push = pu; push_data = pd; poping = po; dont_check = dc;
    updater = 1'($urandom_range(1));
    @(posedge clk);
    model_edge(li, pu, pd, po, dc);
    #1;
    check_all(ctx);
  endtask

  initial begin
    int waits;
    int pops;
    rst = 1'b1; load_init = 1'b0; push = 1'b0; push_data = '0;
    poping = 1'b0; dont_check = 1'b0; updater = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    chk("reset.done_const", 32'(done), 32'd1);
    rst = 1'b0;
    step("idle", 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

    // Single push: top visible at edge k, updated from edge k+1
    step("push1", 1'b0, 1'b1, 16'h00A5, 1'b0, 1'b0);
    chk("push1.top_const", 32'(top_data), 32'h00A5);
    chk("push1.upd_low", 32'(updated), 32'd0);
    step("push1_wait", 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("push1.upd_high", 32'(updated), 32'd1);

    // Fill then overflow, with and without dont_check
    step("clr", 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b0, 1'b1, 16'(i), 1'b0, 1'b0);
    step("ovf", 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    chk("ovf.full", 32'(full), 32'd1);
    chk("ovf.count", 32'(count), 32'd16);
    chk("ovf.top", 32'(top_data), 32'd15);
    chk("ovf.flag", 32'(overflow), 32'd1);
    step("clr2", 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step("fill2", 1'b0, 1'b1, 16'(i), 1'b0, 1'b0);
    step("ovf_dc", 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1);
    chk("ovf_dc.flag", 32'(overflow), 32'd0);

    // Drain from full, then underflow
    for (int j = 1; j <= DEPTH; j++) begin
      step("drain", 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      chk("drain.top_const", 32'(top_data), (j < DEPTH) ? 32'(15 - j) : 32'd0);
    end
    chk("drain.done", 32'(done), 32'd1);
    step("unf", 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("unf.flag", 32'(underflow), 32'd1);
    chk("unf.count", 32'(count), 32'd0);

    // Push with simultaneous pop, then load_init with push
    for (int i = 0; i < 3; i++) step("pre3", 1'b0, 1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
    step("pushpop", 1'b0, 1'b1, 16'h1234, 1'b1, 1'b0);
    chk("pushpop.count", 32'(count), 32'd4);
    chk("pushpop.top", 32'(top_data), 32'h1234);
    step("li_push", 1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    chk("li_push.count", 32'(count), 32'd0);
    chk("li_push.unf_clr", 32'(underflow), 32'd0);

    // Reset arriving mid-push
    step("pre_rst", 1'b0, 1'b1, 16'h0042, 1'b0, 1'b0);
    push = 1'b1; push_data = 16'h0077;
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("rst_mid");
    push = 1'b0;
    #2 rst = 1'b0;

    // Controller loop: load_init, push, wait-for-updated x3, pop until done
    step("ctl_li", 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      step("ctl_push", 1'b0, 1'b1, 16'(16'h0A00 + r), 1'b0, 1'b0);
      waits = 0;
      while (updated !== 1'b1 && waits < 8) begin
        step("ctl_wait", 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        waits++;
      end
      chk("ctl.upd_latency", 32'(waits), 32'd1);
    end
    pops = 0;
    do begin
      step("ctl_pop", 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      pops++;
    end while (done !== 1'b1 && pops < 8);
    chk("ctl.pops_to_done", 32'(pops), 32'd3);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      step("rand", 1'($urandom_range(99) < 3), 1'($urandom_range(99) < 45),
           16'($urandom), 1'($urandom_range(99) < 45), 1'($urandom_range(99) < 20));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
# stack_unit

LIFO operand stack for the backtracking datapath. The sequencing controller drives it with `load_init`, `push`, `poping` and `dont_check`. It returns `updated`, the handshake that releases the controller from its stack-wait state, and `done`, the empty flag that ends the pop/result loop. It holds the stored operand frames, exposes the current top to the ALU/result logic, and flags misuse with sticky error bits.

## Interface
Parameters:
- DATA_W, 16, width of one stack entry
- DEPTH, 16, number of entries (power of two, ≥2)
- PTR_W, $clog2(DEPTH)+1, width of the occupancy count

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- load_init  in  1  synchronous clear of stack and flags
- push  in  1  write `push_data` as the new top
- push_data  in  DATA_W  entry to push
- poping  in  1  discard the current top
- dont_check  in  1  suppress overflow/underflow flag updates
- updater  in  1  controller waiting for `updated` (status only, no effect on state)
- updated  out  1  last push committed and top is valid
- done  out  1  stack empty
- full  out  1  count == DEPTH
- top_data  out  DATA_W  current top entry (registered)
- count  out  PTR_W  number of entries held
- overflow  out  1  sticky: push attempted while full
- underflow  out  1  sticky: pop attempted while empty

## Operation
- Storage is a DEPTH×DATA_W register array plus a count register. Slot count-1 is the top.
- Internal FSM has 3 states:
  - S_IDLE: after reset or load_init; updated=0.
  - S_WRITE: one cycle after an accepted push; updated=0.
  - S_READY: updated=1.
- Transitions:
  - IDLE/READY --accepted push--> WRITE
  - WRITE --> READY unconditionally
  - READY --pop--> READY
  - any --load_init--> IDLE
  - A push arriving in WRITE is accepted and the FSM stays in WRITE.
- Push accept: when not full, mem[count] <= push_data, count <= count+1.
- Push while full: no write, count unchanged, overflow <= 1 unless dont_check, FSM unchanged.
- Pop accept: when count>0, count <= count-1, top_data <= mem[count-2] (0 if count==1).
- Pop while empty: no change, underflow <= 1 unless dont_check.
- Priority, highest first: load_init, then push, then poping. A pop in the same cycle as a push is dropped silently with no error.
- load_init sets count=0, top_data=0, clears overflow/underflow, FSM→IDLE. Array contents are not cleared.
- done = (count==0), combinational from the count register. full = (count==DEPTH).
- updated is a decoded FSM output (state==S_READY). It is unaffected by updater.

## Timing
- Reset (async, immediate) values: count=0, top_data=0, updated=0, done=1, full=0, overflow=0, underflow=0, FSM=S_IDLE.
- Push sampled at edge k: count and the array update at edge k, top_data=push_data from edge k, updated rises at edge k+1. This is 1 cycle of push-to-updated latency, so a controller pulsing push for one cycle sees updated on the second cycle of its wait state.
- Pop sampled at edge k: count, top_data and done are valid after edge k. The controller's pop-check state therefore sees a fresh done on the cycle after its pop-pulse state.
- Back-to-back pushes on every cycle are legal. updated stays 0 until the cycle after the last push.
- Sticky errors set at the offending edge and hold until load_init or rst.
- rst mid-push: the write is lost and all outputs return to their reset values.

## Test plan
- Reset then idle: assert rst → count=0, done=1, updated=0, top_data=0, no errors.
- Single push: push 0x00A5 at edge k → count=1, top_data=0x00A5, done=0 after edge k; updated=1 from edge k+1.
- Fill and overflow: push 0..15 (DEPTH=16), then push 0xFFFF → full=1, count=16, top_data=15, overflow=1. Repeat with dont_check=1 → overflow stays 0.
- Drain: from full, pulse poping 16 times → top_data steps 14,13,…,0,0 and done=1 after the 16th; a 17th pop → underflow=1, count stays 0.
- Simultaneous events: push 0x1234 with poping=1 at count=3 → count=4, top_data=0x1234, no error. load_init with push in the same cycle → count=0, FSM IDLE, errors cleared.
- Controller loop: drive the sequence load_init, push, wait-for-updated, repeat ×3, then pop until done → updated is seen exactly one cycle after each push; done asserts after the third pop.
